instr_fetch: RTL and testbench

Instruction fetch stage for the milano core: the initiator that drives the combinational instruction ROM. It owns the program counter and issues `rom_addr`/`rom_en` each cycle. It captures the returned word into an IF/ID output register with a valid/ready handshake toward decode, and handles branch/jump redirects and halt.

---
 rtl/milano_pkg.sv | 19 +
 rtl/if_id_reg.sv | 45 ++++
 rtl/instr_fetch.sv | 93 +++++++++
 tb/tb_instr_fetch.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/milano_pkg.sv
// Shared types and constants for the milano core front end.
package milano_pkg;

  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } fetch_state_e;

  localparam int          INSTR_W           = 32;
  localparam logic [31:0] PC_INC            = 32'd4;
  localparam logic [31:0] DEFAULT_BOOT_ADDR = 32'h0000_0000;

  // Instructions are word aligned; the low two address bits carry no meaning.
  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID output register: holds one fetched word and its PC under a valid/ready
// handshake. Flush beats load, load beats drain, otherwise contents are held.
module if_id_reg
  import milano_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_BOOT_ADDR
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_load,
  input  logic               i_drain,
  input  logic               i_flush,
  input  logic [INSTR_W-1:0] i_instr,
  input  logic [31:0]        i_pc,
  output logic               o_valid,
  output logic [INSTR_W-1:0] o_instr,
  output logic [31:0]        o_pc
);

  logic               r_valid;
  logic [INSTR_W-1:0] r_instr;
  logic [31:0]        r_pc;

  // Capture, drain or flush the output word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_instr <= {INSTR_W{1'b0}};
      r_pc    <= RESET_PC;
    end else if (i_flush) begin
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_instr <= i_instr;
      r_pc    <= i_pc;
    end else if (i_drain) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_instr = r_instr;
  assign o_pc    = r_pc;

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the PC, drives the combinational ROM and feeds
// decode through the IF/ID register, with redirect and halt handling.
module instr_fetch
  import milano_pkg::*;
#(
  parameter logic [31:0] BOOT_ADDR = DEFAULT_BOOT_ADDR
) (
  input  logic               clk,
  input  logic               rst,
  output logic [31:0]        rom_addr,
  output logic               rom_en,
  input  logic [INSTR_W-1:0] rom_instr,
  input  logic               redirect_valid,
  input  logic [31:0]        redirect_pc,
  input  logic               halt,
  output logic               id_valid,
  input  logic               id_ready,
  output logic [INSTR_W-1:0] id_instr,
  output logic [31:0]        id_pc,
  output logic [31:0]        fetch_cnt
);

  fetch_state_e r_state;
  fetch_state_e w_state_nxt;
  logic [31:0]  r_pc;
  logic [31:0]  r_fetch_cnt;
  logic         w_fire;
  logic         w_drain;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= BOOT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and fetch-fire decision; a redirect freezes the state.
  always_comb begin
    w_state_nxt = r_state;
    w_fire      = 1'b0;
    if (redirect_valid) begin
      w_state_nxt = r_state;
    end else begin
      case (r_state)
        BOOT:    w_state_nxt = RUN;
        RUN:     w_state_nxt = halt ? HALTED : RUN;
        HALTED:  w_state_nxt = halt ? HALTED : RUN;
        default: w_state_nxt = BOOT;
      endcase
      if ((r_state == RUN) && !halt && (!id_valid || id_ready)) begin
        w_fire = 1'b1;
      end else begin
        w_fire = 1'b0;
      end
    end
  end

  // Program counter and fired-fetch counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc        <= BOOT_ADDR;
      r_fetch_cnt <= 32'd0;
    end else if (redirect_valid) begin
      r_pc <= align_word(redirect_pc);
    end else if (w_fire) begin
      r_pc        <= r_pc + PC_INC;
      r_fetch_cnt <= r_fetch_cnt + 32'd1;
    end
  end

  assign w_drain   = id_valid && id_ready;
  assign rom_addr  = r_pc;
  assign rom_en    = w_fire;
  assign fetch_cnt = r_fetch_cnt;

  if_id_reg #(
    .RESET_PC (BOOT_ADDR)
  ) u_if_id_reg (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_fire),
    .i_drain (w_drain),
    .i_flush (redirect_valid),
    .i_instr (rom_instr),
    .i_pc    (r_pc),
    .o_valid (id_valid),
    .o_instr (id_instr),
    .o_pc    (id_pc)
  );

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed scenarios plus random stimulus
// compared against a rule-level reference model of the fetch stage.
module tb_instr_fetch;

  logic        clk;
  logic        rst;
  logic [31:0] rom_addr;
  logic        rom_en;
  logic [31:0] rom_instr;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        halt;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic [31:0] fetch_cnt;

  logic [31:0] rom_addr2;
  logic        rom_en2;
  logic [31:0] rom_instr2;
  logic        redirect_valid2;
  logic [31:0] redirect_pc2;
  logic        halt2;
  logic        id_valid2;
  logic        id_ready2;
  logic [31:0] id_instr2;
  logic [31:0] id_pc2;
  logic [31:0] fetch_cnt2;

  int errors = 0;
  int checks = 0;

  // Reference model state: mode 0 = booting, 1 = running, 2 = halted.
  int          m_mode;
  logic [31:0] m_pc;
  logic        m_valid;
  logic [31:0] m_instr;
  logic [31:0] m_idpc;
  logic [31:0] m_cnt;
  logic        cur_rdy, cur_hl, cur_rv;

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    if (a == 32'h0000_0000) return 32'h0000_0013;
    else if (a == 32'h0000_0004) return 32'h0010_0093;
    else return (a * 32'h9E37_79B1) ^ 32'hA5A5_0013;
  endfunction

  assign rom_instr  = rom_en  ? rom_word(rom_addr)  : 32'h0;
  assign rom_instr2 = rom_en2 ? rom_word(rom_addr2) : 32'h0;

  instr_fetch dut (
    .clk(clk), .rst(rst), .rom_addr(rom_addr), .rom_en(rom_en),
    .rom_instr(rom_instr), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .halt(halt), .id_valid(id_valid),
    .id_ready(id_ready), .id_instr(id_instr), .id_pc(id_pc),
    .fetch_cnt(fetch_cnt)
  );

  instr_fetch #(.BOOT_ADDR(32'hFFFF_FFF8)) dut_wrap (
    .clk(clk), .rst(rst), .rom_addr(rom_addr2), .rom_en(rom_en2),
    .rom_instr(rom_instr2), .redirect_valid(redirect_valid2),
    .redirect_pc(redirect_pc2), .halt(halt2), .id_valid(id_valid2),
    .id_ready(id_ready2), .id_instr(id_instr2), .id_pc(id_pc2),
    .fetch_cnt(fetch_cnt2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_mode  = 0;
    m_pc    = 32'h0;
    m_valid = 1'b0;
    m_instr = 32'h0;
    m_idpc  = 32'h0;
    m_cnt   = 32'h0;
  endtask

  function automatic logic model_fires(input logic rdy, input logic hl, input logic rv);
    return (m_mode == 1) && !hl && !rv && (!m_valid || rdy);
  endfunction

  task automatic model_step(input logic rdy, input logic hl, input logic rv, input logic [31:0] rp);
    logic go;
    go = model_fires(rdy, hl, rv);
    if (rv) begin
      m_pc    = rp & 32'hFFFF_FFFC;
      m_valid = 1'b0;
    end else if (go) begin
      m_instr = rom_word(m_pc);
      m_idpc  = m_pc;
      m_valid = 1'b1;
      m_pc    = m_pc + 32'd4;
      m_cnt   = m_cnt + 32'd1;
    end else if (m_valid && rdy) begin
      m_valid = 1'b0;
    end
    if (!rv) begin
      if (m_mode == 0) m_mode = 1;
      else if (m_mode == 1 && hl) m_mode = 2;
      else if (m_mode == 2 && !hl) m_mode = 1;
    end
  endtask

  task automatic compare_all();
    check32("rom_en",    {31'b0, rom_en}, {31'b0, model_fires(cur_rdy, cur_hl, cur_rv)});
    check32("rom_addr",  rom_addr, m_pc);
    check32("id_valid",  {31'b0, id_valid}, {31'b0, m_valid});
    check32("id_instr",  id_instr, m_instr);
    check32("id_pc",     id_pc, m_idpc);
    check32("fetch_cnt", fetch_cnt, m_cnt);
  endtask

  // One clock cycle: drive at negedge, check mid-cycle, advance model, take the edge.
  task automatic cyc(input logic rdy, input logic hl, input logic rv, input logic [31:0] rp);
    @(negedge clk);
    id_ready = rdy; halt = hl; redirect_valid = rv; redirect_pc = rp;
    cur_rdy = rdy; cur_hl = hl; cur_rv = rv;
    #1;
    compare_all();
    model_step(rdy, hl, rv, rp);
    @(posedge clk);
  endtask

  task automatic random_run(input int n);
    for (int i = 0; i < n; i++) begin
      cyc(($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < 2),
          ($urandom_range(0, 9) == 0), 32'($urandom_range(0, 511)));
    end
  endtask

  initial begin
    logic [31:0] held_pc;
    logic [31:0] held_instr;
    rst = 1'b1;
    id_ready = 1'b0; halt = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
    id_ready2 = 1'b1; halt2 = 1'b0; redirect_valid2 = 1'b0; redirect_pc2 = 32'h0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    check32("wrap_reset_rom_addr", rom_addr2, 32'hFFFF_FFF8);
    check32("wrap_reset_id_pc", id_pc2, 32'hFFFF_FFF8);
    check32("reset_id_pc", id_pc, 32'h0);

    // Reset/boot and PC wrap on the second instance.
    cyc(1'b1, 1'b0, 1'b0, 32'h0);
    #2 check32("boot_id_valid_low", {31'b0, id_valid}, 32'h0);
    cyc(1'b1, 1'b0, 1'b0, 32'h0);
    #2 check32("first_id_pc", id_pc, 32'h0);
    check32("first_id_instr", id_instr, 32'h0000_0013);
    check32("wrap_pc0", id_pc2, 32'hFFFF_FFF8);
    cyc(1'b1, 1'b0, 1'b0, 32'h0);
    #2 check32("second_id_pc", id_pc, 32'h4);
    check32("second_id_instr", id_instr, 32'h0010_0093);
    check32("fetch_cnt_two", fetch_cnt, 32'd2);
    check32("wrap_pc1", id_pc2, 32'hFFFF_FFFC);
    cyc(1'b1, 1'b0, 1'b0, 32'h0);
    #2 check32("wrap_pc2", id_pc2, 32'h0000_0000);

    // Backpressure for three cycles, then release.
    held_pc = id_pc; held_instr = id_instr;
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b0, 1'b0, 32'h0);
      #2 check32("bp_id_pc_stable", id_pc, held_pc);
      check32("bp_id_instr_stable", id_instr, held_instr);
    end
    cyc(1'b1, 1'b0, 1'b0, 32'h0);
    #2 check32("bp_release_next", id_pc, held_pc + 32'd4);

    // Redirect while streaming.
    cyc(1'b1, 1'b0, 1'b1, 32'h0000_0013);
    #2 check32("redir_flush", {31'b0, id_valid}, 32'h0);
    check32("redir_rom_addr", rom_addr, 32'h10);
    cyc(1'b1, 1'b0, 1'b0, 32'h0);
    #2 check32("redir_target_id_pc", id_pc, 32'h10);

    // Redirect, halt and accept in the same cycle while halted.
    cyc(1'b0, 1'b1, 1'b0, 32'h0);
    cyc(1'b1, 1'b1, 1'b1, 32'h0000_0203);
    #2 check32("rha_flush", {31'b0, id_valid}, 32'h0);
    check32("rha_rom_addr", rom_addr, 32'h200);
    cyc(1'b1, 1'b0, 1'b0, 32'h0);
    cyc(1'b1, 1'b0, 1'b0, 32'h0);
    #2 check32("rha_target_id_pc", id_pc, 32'h200);

    random_run(300);

    // Asynchronous reset between edges.
    cyc(1'b1, 1'b0, 1'b0, 32'h0);
    cyc(1'b1, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check32("arst_id_valid", {31'b0, id_valid}, 32'h0);
    check32("arst_id_instr", id_instr, 32'h0);
    check32("arst_id_pc", id_pc, 32'h0);
    check32("arst_rom_addr", rom_addr, 32'h0);
    check32("arst_rom_en", {31'b0, rom_en}, 32'h0);
    check32("arst_fetch_cnt", fetch_cnt, 32'h0);
    model_reset();
    @(posedge clk);
    #1 rst = 1'b0;
    cyc(1'b1, 1'b0, 1'b0, 32'h0);
    cyc(1'b1, 1'b0, 1'b0, 32'h0);
    #2 check32("arst_restart_id_pc", id_pc, 32'h0);
    check32("arst_restart_instr", id_instr, 32'h0000_0013);

    random_run(300);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
